// File: rtl/bcd_xs3_seq_conv.sv
// Digit-serial BCD <-> Excess-3 converter, one digit per clock, LSD first, with valid/ready on both sides.
// Optional XS3->BCD direction (in_mode port) is enabled by defining BCD_XS3_REVERSE_EN.
module bcd_xs3_seq_conv #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
`ifdef BCD_XS3_REVERSE_EN
  input  logic                  in_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [4*DIGITS-1:0]   sh;
  logic [4*DIGITS-1:0]   res;
  logic [4*DIGITS-1:0]   res_next;
  logic [DIGITS-1:0]     err_acc;
  logic [DIGITS-1:0]     err_next;
  logic [3:0]            digit_cnv;
  logic                  digit_err;
`ifdef BCD_XS3_REVERSE_EN
  logic                  mode;
`endif

  // Result packing is {err, digit}; illegal codes map to zero so no wrap is visible.
  function automatic logic [4:0] to_xs3(input logic [3:0] d);
    if (d <= 4'd9) return {1'b0, d + 4'd3};
    return 5'b1_0000;
  endfunction

`ifdef BCD_XS3_REVERSE_EN
  function automatic logic [4:0] to_bcd(input logic [3:0] d);
    if (d >= 4'd3 && d <= 4'd12) return {1'b0, d - 4'd3};
    return 5'b1_0000;
  endfunction
`endif

  always_comb begin
`ifdef BCD_XS3_REVERSE_EN
    {digit_err, digit_cnv} = mode ? to_bcd(sh[3:0]) : to_xs3(sh[3:0]);
`else
    {digit_err, digit_cnv} = to_xs3(sh[3:0]);
`endif
    res_next                      = res;
    res_next[4*int'(cnt) +: 4]    = digit_cnv;
    err_next                      = err_acc;
    err_next[int'(cnt)]           = digit_err;
  end

  // Working registers (sh/res/err_acc) are fully rewritten per word, so they need no reset;
  // the visible outputs only update when a whole word has completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sh       <= in_data;
`ifdef BCD_XS3_REVERSE_EN
            mode     <= in_mode;
`endif
            err_acc  <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          sh      <= sh >> 4;
          res     <= res_next;
          err_acc <= err_next;
          if (cnt == LAST) begin
            cnt       <= '0;
            out_data  <= res_next;
            out_err   <= err_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_xs3_seq_conv.sv
// Directed-vector bench for bcd_xs3_seq_conv: DIGITS=4 main instance plus a DIGITS=1 instance.
module tb_bcd_xs3_seq_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, in_mode;
  logic [15:0] in_data, out_data;
  logic [3:0]  out_err;

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_in_mode;
  logic [3:0]  d1_in_data, d1_out_data;
  logic [0:0]  d1_out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_xs3_seq_conv #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef BCD_XS3_REVERSE_EN
    .in_mode(in_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  bcd_xs3_seq_conv #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
`ifdef BCD_XS3_REVERSE_EN
    .in_mode(d1_in_mode),
`endif
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data), .out_err(d1_out_err)
  );

  typedef struct {
    logic [15:0] din;
    logic        mode;
    logic [15:0] dout;
    logic [3:0]  err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Waits for in_ready, performs one handshake, then measures latency and checks the result.
  task automatic run_vec(input logic [15:0] din, input logic m, input logic [15:0] dout,
                         input logic [3:0] e, input string nm);
    int t;
    int lat;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = din;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = ~m;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd5);
    chk({nm, "_data"}, 32'(out_data), 32'(dout));
    chk({nm, "_err"}, 32'(out_err), 32'(e));
  endtask

  initial begin
    logic [15:0] ws[3];
    logic [15:0] wr[3];
    int hs[3];
    int idx, ridx, cyc, lat;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_in_data = '0; d1_in_mode = 1'b0; d1_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);

    vt.push_back('{16'h1985, 1'b0, 16'h4CB8, 4'b0000});
    vt.push_back('{16'h12A9, 1'b0, 16'h450C, 4'b0010});
    vt.push_back('{16'h0000, 1'b0, 16'h3333, 4'b0000});
    vt.push_back('{16'h9999, 1'b0, 16'hCCCC, 4'b0000});
    vt.push_back('{16'hFFFF, 1'b0, 16'h0000, 4'b1111});
    vt.push_back('{16'h7B3E, 1'b0, 16'hA060, 4'b0101});
`ifdef BCD_XS3_REVERSE_EN
    vt.push_back('{16'h4CB8, 1'b1, 16'h1985, 4'b0000});
    vt.push_back('{16'h3D02, 1'b1, 16'h0000, 4'b0111});
    vt.push_back('{16'hC3A6, 1'b1, 16'h9073, 4'b0000});
`endif

    foreach (vt[i]) run_vec(vt[i].din, vt[i].mode, vt[i].dout, vt[i].err, $sformatf("vec%0d", i));

    // Single-digit sweep in digit 0; upper digits are 0 and map to 3.
    for (int d = 0; d < 16; d++) begin
      run_vec({12'h000, 4'(d)}, 1'b0,
              {12'h333, (d <= 9) ? 4'(d + 3) : 4'h0},
              (d <= 9) ? 4'b0000 : 4'b0001, $sformatf("sweep%0d", d));
    end

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    run_vec(16'h1985, 1'b0, 16'h4CB8, 4'b0000, "bp");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'h4CB8);
      chk("bp_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_ready", 32'(in_ready),  32'd1);
    chk("bp_rel_hold",  32'(out_data),  32'h4CB8);
    repeat (2) @(negedge clk);
    chk("idle_ordy_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // Back-to-back words with in_valid held high.
    ws[0] = 16'h0123; ws[1] = 16'h4567; ws[2] = 16'h89AB;
    wr[0] = 16'h3456; wr[1] = 16'h789A; wr[2] = 16'hBC00;
    idx = 0; ridx = 0; cyc = 0;
    while (ridx < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk($sformatf("b2b_data%0d", ridx), 32'(out_data), 32'(wr[ridx]));
        ridx++;
      end
      if (idx < 3) begin
        in_valid = 1'b1;
        in_data  = ws[idx];
        in_mode  = 1'b0;
        if (in_ready) begin
          hs[idx] = cyc;
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(ridx), 32'd3);
    chk("b2b_period1", 32'(hs[1] - hs[0]), 32'd6);
    chk("b2b_period2", 32'(hs[2] - hs[1]), 32'd6);

    // Reset during the second conversion cycle discards the word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstc_in_ready",  32'(in_ready),  32'd1);
    chk("rstc_out_valid", 32'(out_valid), 32'd0);
    chk("rstc_out_data",  32'(out_data),  32'd0);
    chk("rstc_out_err",   32'(out_err),   32'd0);
    cyc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    chk("rstc_no_emit", 32'(cyc), 32'd0);

    // DIGITS=1 instance: latency 2.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d1_in_valid = 1'b1;
      d1_in_data  = (k == 0) ? 4'h7 : 4'hC;
      @(posedge clk);
      @(negedge clk);
      d1_in_valid = 1'b0;
      d1_in_data  = 4'h0;
      lat = 1;
      while (!d1_out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("d1_lat%0d", k),  32'(lat), 32'd2);
      chk($sformatf("d1_data%0d", k), 32'(d1_out_data), (k == 0) ? 32'hA : 32'h0);
      chk($sformatf("d1_err%0d", k),  32'(d1_out_err),  (k == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
